eb1_uart_rx_cfg: RTL and testbench
==================================

EB1_UART_RX_CFG -- requirements
Module: eb1_uart_rx_cfg

Interface
REQ-001 Parameter DATA_W, default 8, maximum data bits per frame (legal 5..9).
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, 2..16).
REQ-003 i_Clock  input  1  clock, all logic on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-006 CLKS_PER_BIT  input  16  clocks per bit; values below 4 SHALL be treated as 4.
REQ-007 i_Data_Bits  input  4  data bits per frame; below 5 treated as 5, above DATA_W treated as DATA_W.
REQ-008 i_Two_Stop  input  1  1 = two stop bits expected, 0 = one.
REQ-009 i_Rx_Ready  input  1  consumer accepts head FIFO entry.
REQ-010 o_Rx_Valid  output  1  FIFO non-empty.
REQ-011 o_Rx_Data  output  DATA_W  head entry data, LSB = first received bit, unused upper bits 0.
REQ-012 o_Frame_Err  output  1  head entry had a stop bit sampled low.
REQ-013 o_Parity_Err  output  1  head entry failed parity check.
REQ-014 o_Overrun  output  1  one-cycle pulse: completed frame dropped, FIFO full.
REQ-015 o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  current entry count.

Function
REQ-016 i_Rx_Serial SHALL pass a two-flop synchroniser (reset value 1) before any use; all sampling uses the synchronised value.
REQ-017 States: IDLE, START, DATA, PARITY, STOP1, STOP2; bit counter 16 bits, bit index 4 bits.
REQ-018 IDLE: synchronised line 0 -> START, counter 0; CLKS_PER_BIT, i_Data_Bits, i_Two_Stop (and parity controls) latched at this transition; later changes ignored until next IDLE.
REQ-019 START: at counter == (CLKS_PER_BIT-1)>>1 line 0 -> DATA, counter 0; line 1 -> IDLE (glitch, nothing pushed).
REQ-020 Every later bit sampled when counter == CLKS_PER_BIT-1, counter then 0.
REQ-021 DATA: sample into data[index]; after latched data-bit count -> PARITY if parity enabled, else STOP1.
REQ-022 STOP1 sample 0 sets frame error; -> STOP2 if two stops latched, else push; STOP2 sample 0 also sets frame error, then push.
REQ-023 Push occurs the cycle of the final stop sample; FSM returns to IDLE that same cycle (no cleanup state), so a start bit immediately following is detected.
REQ-024 FIFO entry = {parity err, frame err, data}; outputs show head entry; o_Rx_Data/flags undefined-but-stable while o_Rx_Valid = 0.
REQ-025 Pop when o_Rx_Valid & i_Rx_Ready; i_Rx_Ready ignored when empty.
REQ-026 Push when full with no simultaneous pop: entry dropped, o_Overrun high one cycle, FIFO unchanged.
REQ-027 Push and pop same cycle when full: both performed, no overrun, count unchanged.
REQ-028 Push and pop same cycle when non-full, non-empty: count unchanged; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 rst_ni low: FSM IDLE, counters 0, FIFO empty, o_Rx_Valid 0, o_Fifo_Count 0, o_Overrun 0, o_Rx_Data 0, error outputs 0, synchroniser 1.
REQ-030 Reset mid-frame SHALL abandon the frame with no push; after release the FSM SHALL not start until a fresh falling edge is synchronised.

Configuration
REQ-031 Macro EB1_UART_RX_PARITY_EN defined: inputs i_Parity_En (1) and i_Parity_Odd (1) exist, latched per REQ-018; PARITY state samples one bit; error when XOR(data bits, parity bit) != i_Parity_Odd.
REQ-032 Macro undefined: those inputs and PARITY state absent, o_Parity_Err constant 0, stored parity bit tied 0.

Verification
REQ-033 CLKS_PER_BIT=16, 8N1 byte 0xA5 -> after final stop sample, o_Rx_Valid=1, o_Rx_Data=0xA5, errors 0, count 1.
REQ-034 i_Data_Bits=5, two stops, send 0x1F3 pattern low 5 bits 0x13 -> o_Rx_Data=0x13, upper bits 0.
REQ-035 Stop bit driven 0 on 0x3C -> entry 0x3C with o_Frame_Err=1; 1-clock-wide 0 pulse on idle line -> nothing pushed.
REQ-036 FIFO_DEPTH=4, i_Rx_Ready=0, five frames -> count 4, o_Overrun one-cycle pulse on fifth, first four bytes read back in order.
REQ-037 With EB1_UART_RX_PARITY_EN, even parity, 0x07 with parity bit 0 -> o_Parity_Err=1; parity bit 1 -> 0.
REQ-038 rst_ni pulsed low during DATA bit 3 -> no push, count 0; next clean frame 0x5A received correctly.

Source files
------------

// File: rtl/eb1_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : eb1_uart_rx_cfg
// Brief    : Runtime-configurable UART receiver with a small receive FIFO.
//            Bit period, data-bit count (5..DATA_W) and stop-bit count are
//            latched at each start-bit detection. Every received frame is
//            pushed as {parity err, frame err, data}.
//            Optional feature macro: EB1_UART_RX_PARITY_EN adds
//            i_Parity_En / i_Parity_Odd and a parity-bit state.
// Revision : 1.0 - initial release
// ============================================================================
module eb1_uart_rx_cfg #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_Clock,
    input  logic                          rst_ni,
    input  logic                          i_Rx_Serial,
    input  logic [15:0]                   CLKS_PER_BIT,
    input  logic [3:0]                    i_Data_Bits,
    input  logic                          i_Two_Stop,
`ifdef EB1_UART_RX_PARITY_EN
    input  logic                          i_Parity_En,
    input  logic                          i_Parity_Odd,
`endif
    input  logic                          i_Rx_Ready,
    output logic                          o_Rx_Valid,
    output logic [DATA_W-1:0]             o_Rx_Data,
    output logic                          o_Frame_Err,
    output logic                          o_Parity_Err,
    output logic                          o_Overrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = DATA_W + 2;

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [3:0]         c_MAX_BITS = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP1  = 3'd3,
        S_STOP2  = 3'd4
`ifdef EB1_UART_RX_PARITY_EN
       ,S_PARITY = 3'd5
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Line synchroniser and post-reset arming
    // ------------------------------------------------------------------
    logic       r_Rx_Meta;
    logic       r_Rx_Sync;
    logic [1:0] r_Fill;
    logic       r_Armed;

    // Two-flop synchroniser; r_Fill marks when r_Rx_Sync holds a real line
    // sample, so a line already low at reset release never starts a frame.
    always_ff @(posedge i_Clock or negedge rst_ni) begin
        if (!rst_ni) begin
            r_Rx_Meta <= 1'b1;
            r_Rx_Sync <= 1'b1;
            r_Fill    <= 2'b00;
            r_Armed   <= 1'b0;
        end else begin
            r_Rx_Meta <= i_Rx_Serial;
            r_Rx_Sync <= r_Rx_Meta;
            r_Fill    <= {r_Fill[0], 1'b1};
            if (r_Fill[1] && r_Rx_Sync) begin
                r_Armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t              r_State;
    logic [15:0]         r_Cnt;
    logic [3:0]          r_Bit_Idx;
    logic [15:0]         r_Cpb;
    logic [3:0]          r_Nbits;
    logic                r_Two_Stop;
    logic [DATA_W-1:0]   r_Data;
    logic                r_Frame_Err;

    logic [15:0]         w_Cpb_Clamp;
    logic [3:0]          w_Nbits_Clamp;
    logic [15:0]         w_Half;
    logic                w_Bit_Tick;
    logic                w_Push;
    logic                w_Push_Ferr;
    logic                w_Push_Perr;

    assign w_Cpb_Clamp   = (CLKS_PER_BIT < 16'd4) ? 16'd4 : CLKS_PER_BIT;
    assign w_Nbits_Clamp = (i_Data_Bits < 4'd5)       ? 4'd5 :
                           (i_Data_Bits > c_MAX_BITS) ? c_MAX_BITS : i_Data_Bits;
    assign w_Half        = (r_Cpb - 16'd1) >> 1;
    assign w_Bit_Tick    = (r_Cnt == (r_Cpb - 16'd1));

    // The frame is pushed on the final stop-bit sample, in the same cycle the
    // FSM drops back to IDLE.
    assign w_Push      = w_Bit_Tick &&
                         (((r_State == S_STOP1) && !r_Two_Stop) || (r_State == S_STOP2));
    assign w_Push_Ferr = !r_Rx_Sync || ((r_State == S_STOP2) && r_Frame_Err);

`ifdef EB1_UART_RX_PARITY_EN
    logic r_Par_En;
    logic r_Par_Odd;
    logic r_Par_Err;
    logic w_Par_Calc;

    assign w_Par_Calc  = (^r_Data) ^ r_Rx_Sync;
    assign w_Push_Perr = r_Par_Err;
`else
    assign w_Push_Perr = 1'b0;
`endif

    // Bit-timing FSM: mid-bit start validation, then one sample per bit period.
    always_ff @(posedge i_Clock or negedge rst_ni) begin
        if (!rst_ni) begin
            r_State     <= S_IDLE;
            r_Cnt       <= 16'd0;
            r_Bit_Idx   <= 4'd0;
            r_Cpb       <= 16'd4;
            r_Nbits     <= 4'd5;
            r_Two_Stop  <= 1'b0;
            r_Data      <= '0;
            r_Frame_Err <= 1'b0;
`ifdef EB1_UART_RX_PARITY_EN
            r_Par_En    <= 1'b0;
            r_Par_Odd   <= 1'b0;
            r_Par_Err   <= 1'b0;
`endif
        end else begin
            case (r_State)
                S_IDLE: begin
                    r_Cnt     <= 16'd0;
                    r_Bit_Idx <= 4'd0;
                    if (r_Armed && !r_Rx_Sync) begin
                        r_State     <= S_START;
                        r_Cpb       <= w_Cpb_Clamp;
                        r_Nbits     <= w_Nbits_Clamp;
                        r_Two_Stop  <= i_Two_Stop;
                        r_Data      <= '0;
                        r_Frame_Err <= 1'b0;
`ifdef EB1_UART_RX_PARITY_EN
                        r_Par_En    <= i_Parity_En;
                        r_Par_Odd   <= i_Parity_Odd;
                        r_Par_Err   <= 1'b0;
`endif
                    end
                end

                S_START: begin
                    if (r_Cnt == w_Half) begin
                        r_Cnt   <= 16'd0;
                        r_State <= r_Rx_Sync ? S_IDLE : S_DATA;
                    end else begin
                        r_Cnt <= r_Cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_Bit_Tick) begin
                        r_Cnt <= 16'd0;
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_Bit_Idx == 4'(i)) begin
                                r_Data[i] <= r_Rx_Sync;
                            end
                        end
                        if (r_Bit_Idx == (r_Nbits - 4'd1)) begin
                            r_Bit_Idx <= 4'd0;
`ifdef EB1_UART_RX_PARITY_EN
                            r_State   <= r_Par_En ? S_PARITY : S_STOP1;
`else
                            r_State   <= S_STOP1;
`endif
                        end else begin
                            r_Bit_Idx <= r_Bit_Idx + 4'd1;
                        end
                    end else begin
                        r_Cnt <= r_Cnt + 16'd1;
                    end
                end

`ifdef EB1_UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_Bit_Tick) begin
                        r_Cnt     <= 16'd0;
                        r_Par_Err <= (w_Par_Calc != r_Par_Odd);
                        r_State   <= S_STOP1;
                    end else begin
                        r_Cnt <= r_Cnt + 16'd1;
                    end
                end
`endif

                S_STOP1: begin
                    if (w_Bit_Tick) begin
                        r_Cnt       <= 16'd0;
                        r_Frame_Err <= !r_Rx_Sync;
                        r_State     <= r_Two_Stop ? S_STOP2 : S_IDLE;
                    end else begin
                        r_Cnt <= r_Cnt + 16'd1;
                    end
                end

                S_STOP2: begin
                    if (w_Bit_Tick) begin
                        r_Cnt       <= 16'd0;
                        r_Frame_Err <= r_Frame_Err | !r_Rx_Sync;
                        r_State     <= S_IDLE;
                    end else begin
                        r_Cnt <= r_Cnt + 16'd1;
                    end
                end

                default: begin
                    r_State <= S_IDLE;
                    r_Cnt   <= 16'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_Mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_Wr_Ptr;
    logic [c_PTR_W-1:0] r_Rd_Ptr;
    logic [c_CNT_W-1:0] r_Count;
    logic               r_Overrun;

    logic               w_Full;
    logic               w_Pop;
    logic               w_Wr;
    logic [c_ENT_W-1:0] w_Head;

    assign w_Full = (r_Count == c_FULL);
    assign w_Pop  = (r_Count != '0) && i_Rx_Ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_Wr   = w_Push && (!w_Full || w_Pop);
    assign w_Head = r_Mem[r_Rd_Ptr];

    // FIFO storage, pointers, occupancy and the overrun pulse.
    always_ff @(posedge i_Clock or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_Mem[i] <= '0;
            end
            r_Wr_Ptr  <= '0;
            r_Rd_Ptr  <= '0;
            r_Count   <= '0;
            r_Overrun <= 1'b0;
        end else begin
            r_Overrun <= w_Push && w_Full && !w_Pop;
            if (w_Wr) begin
                r_Mem[r_Wr_Ptr] <= {w_Push_Perr, w_Push_Ferr, r_Data};
                r_Wr_Ptr        <= r_Wr_Ptr + c_PTR_ONE;
            end
            if (w_Pop) begin
                r_Rd_Ptr <= r_Rd_Ptr + c_PTR_ONE;
            end
            case ({w_Wr, w_Pop})
                2'b10:   r_Count <= r_Count + c_CNT_ONE;
                2'b01:   r_Count <= r_Count - c_CNT_ONE;
                default: r_Count <= r_Count;
            endcase
        end
    end

    assign o_Rx_Valid   = (r_Count != '0);
    assign o_Rx_Data    = w_Head[DATA_W-1:0];
    assign o_Frame_Err  = w_Head[DATA_W];
    assign o_Parity_Err = w_Head[DATA_W+1];
    assign o_Overrun    = r_Overrun;
    assign o_Fifo_Count = r_Count;

endmodule
`default_nettype wire

// File: tb/tb_eb1_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_eb1_uart_rx_cfg
// Brief    : Directed self-checking bench for eb1_uart_rx_cfg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eb1_uart_rx_cfg;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] cpb;
    logic [3:0]  nbits;
    logic        two_stop;
    logic        ready;
`ifdef EB1_UART_RX_PARITY_EN
    logic        par_en;
    logic        par_odd;
`endif
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;

    eb1_uart_rx_cfg #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .i_Clock      (clk),
        .rst_ni       (rst_n),
        .i_Rx_Serial  (rx),
        .CLKS_PER_BIT (cpb),
        .i_Data_Bits  (nbits),
        .i_Two_Stop   (two_stop),
`ifdef EB1_UART_RX_PARITY_EN
        .i_Parity_En  (par_en),
        .i_Parity_Odd (par_odd),
`endif
        .i_Rx_Ready   (ready),
        .o_Rx_Valid   (rx_valid),
        .o_Rx_Data    (rx_data),
        .o_Frame_Err  (frame_err),
        .o_Parity_Err (parity_err),
        .o_Overrun    (overrun),
        .o_Fifo_Count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles during which the overrun pulse is high.
    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int clks);
        rx = v;
        tick(clks);
    endtask

    // Start bit, nb data bits LSB first, optional parity, stops, idle gap.
    task automatic send_frame(input logic [8:0] data, input int nb, input int nstop,
                              input logic stop_val, input logic use_par,
                              input logic par_bit, input int clks, input int gap);
        drive_bit(1'b0, clks);
        for (int i = 0; i < nb; i++) drive_bit(data[i], clks);
        if (use_par) drive_bit(par_bit, clks);
        for (int s = 0; s < nstop; s++) drive_bit((s == 0) ? stop_val : 1'b1, clks);
        rx = 1'b1;
        if (gap > 0) tick(gap);
    endtask

    task automatic pop_one();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_8n1();
        cpb = 16'd16; nbits = 4'd8; two_stop = 1'b0;
        send_frame(9'h0A5, 8, 1, 1'b1, 1'b0, 1'b0, 16, 8);
        @(negedge clk);
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL a5_valid got=%b exp=1", rx_valid); end
        n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data got=%h exp=a5", rx_data); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL a5_ferr got=%b exp=0", frame_err); end
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL a5_perr got=%b exp=0", parity_err); end
        n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL a5_count got=%0d exp=1", fifo_count); end
        @(posedge clk); #1;
        pop_one();
        @(negedge clk);
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL a5_pop_count got=%0d exp=0", fifo_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_five_bits_two_stop();
        cpb = 16'd16; nbits = 4'd5; two_stop = 1'b1;
        send_frame(9'h1F3, 5, 2, 1'b1, 1'b0, 1'b0, 16, 8);
        @(negedge clk);
        n_tests++; if (rx_data !== 8'h13) begin n_fail++; $display("FAIL five_data got=%h exp=13", rx_data); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL five_ferr got=%b exp=0", frame_err); end
        n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL five_count got=%0d exp=1", fifo_count); end
        @(posedge clk); #1;
        pop_one();
    endtask

    task automatic test_clamp();
        // 2 clocks/bit is treated as 4, 15 data bits as 8.
        cpb = 16'd2; nbits = 4'd15; two_stop = 1'b0;
        send_frame(9'h081, 8, 1, 1'b1, 1'b0, 1'b0, 4, 8);
        @(negedge clk);
        n_tests++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL clamp_data got=%h exp=81", rx_data); end
        n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL clamp_count got=%0d exp=1", fifo_count); end
        @(posedge clk); #1;
        pop_one();
        cpb = 16'd16; nbits = 4'd8;
    endtask

    task automatic test_frame_err_glitch();
        cpb = 16'd16; nbits = 4'd8; two_stop = 1'b0;
        send_frame(9'h03C, 8, 1, 1'b0, 1'b0, 1'b0, 16, 40);
        @(negedge clk);
        n_tests++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data got=%h exp=3c", rx_data); end
        n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
        n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL ferr_count got=%0d exp=1", fifo_count); end
        @(posedge clk); #1;
        pop_one();
        drive_bit(1'b0, 1);
        drive_bit(1'b1, 60);
        @(negedge clk);
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL glitch_count got=%0d exp=0", fifo_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        cpb = 16'd16; nbits = 4'd8; two_stop = 1'b0;
        send_frame(9'h096, 8, 1, 1'b1, 1'b0, 1'b0, 16, 0);
        send_frame(9'h069, 8, 1, 1'b1, 1'b0, 1'b0, 16, 8);
        @(negedge clk);
        n_tests++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", fifo_count); end
        n_tests++; if (rx_data !== 8'h96) begin n_fail++; $display("FAIL b2b_first got=%h exp=96", rx_data); end
        @(posedge clk); #1;
        pop_one();
        @(negedge clk);
        n_tests++; if (rx_data !== 8'h69) begin n_fail++; $display("FAIL b2b_second got=%h exp=69", rx_data); end
        @(posedge clk); #1;
        pop_one();
    endtask

    task automatic test_overrun();
        logic [7:0] exp_q [5];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        cpb = 16'd16; nbits = 4'd8; two_stop = 1'b0; ready = 1'b0;
        ovr_cnt = 0;
        for (int f = 0; f < 4; f++) send_frame({1'b0, exp_q[f]}, 8, 1, 1'b1, 1'b0, 1'b0, 16, 8);
        @(negedge clk);
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovr_count4 got=%0d exp=4", fifo_count); end
        n_tests++; if (ovr_cnt !== 0) begin n_fail++; $display("FAIL ovr_early got=%0d exp=0", ovr_cnt); end
        @(posedge clk); #1;
        send_frame({1'b0, exp_q[4]}, 8, 1, 1'b1, 1'b0, 1'b0, 16, 8);
        @(negedge clk);
        n_tests++; if (ovr_cnt !== 1) begin n_fail++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt); end
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovr_count got=%0d exp=4", fifo_count); end
        @(posedge clk); #1;
        for (int f = 0; f < 4; f++) begin
            @(negedge clk);
            n_tests++; if (rx_data !== exp_q[f]) begin n_fail++; $display("FAIL ovr_read%0d got=%h exp=%h", f, rx_data, exp_q[f]); end
            @(posedge clk); #1;
            pop_one();
        end
        @(negedge clk);
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained got=%b exp=0", rx_valid); end
        @(posedge clk); #1;
    endtask

`ifdef EB1_UART_RX_PARITY_EN
    task automatic test_parity();
        cpb = 16'd16; nbits = 4'd8; two_stop = 1'b0; par_en = 1'b1; par_odd = 1'b0;
        send_frame(9'h007, 8, 1, 1'b1, 1'b1, 1'b0, 16, 8);
        @(negedge clk);
        n_tests++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_bad got=%b exp=1", parity_err); end
        @(posedge clk); #1;
        pop_one();
        send_frame(9'h007, 8, 1, 1'b1, 1'b1, 1'b1, 16, 8);
        @(negedge clk);
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_good got=%b exp=0", parity_err); end
        n_tests++; if (rx_data !== 8'h07) begin n_fail++; $display("FAIL par_data got=%h exp=07", rx_data); end
        @(posedge clk); #1;
        pop_one();
        par_en = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h5A;
        cpb = 16'd16; nbits = 4'd8; two_stop = 1'b0;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(b[i], 16);
        drive_bit(b[3], 8);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        drive_bit(b[3], 8);
        drive_bit(1'b1, 200);
        @(negedge clk);
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", rx_valid); end
        @(posedge clk); #1;
        send_frame({1'b0, b}, 8, 1, 1'b1, 1'b0, 1'b0, 16, 8);
        @(negedge clk);
        n_tests++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL rstmid_data got=%h exp=5a", rx_data); end
        n_tests++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL rstmid_after got=%0d exp=1", fifo_count); end
        @(posedge clk); #1;
        pop_one();
    endtask

    initial begin
        rst_n = 1'b0; rx = 1'b1; cpb = 16'd16; nbits = 4'd8; two_stop = 1'b0; ready = 1'b0;
`ifdef EB1_UART_RX_PARITY_EN
        par_en = 1'b0; par_odd = 1'b0;
`endif
        tick(4);
        test_reset();
        rst_n = 1'b1;
        tick(10);
        test_basic_8n1();
        test_five_bits_two_stop();
        test_clamp();
        test_frame_err_glitch();
        test_back_to_back();
        test_overrun();
`ifdef EB1_UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
